// File: rtl/ahb_arbiter_2m.sv
// rtl/ahb_arbiter_2m.sv - Two-master AHB arbiter with burst tracking and locked transfers
// Option macro AHB_ARB_ROUND_ROBIN_EN: round-robin on contention instead of master-1 priority.
module ahb_arbiter_2m (
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       hbusreq0,
    input  logic       hbusreq1,
    input  logic       hlock0,
    input  logic       hlock1,
    input  logic [1:0] htrans,
    input  logic [2:0] hburst,
    input  logic       hready,
    output logic       hgrant0,
    output logic       hgrant1,
    output logic       hmaster,
    output logic       hmastlock
);
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {ST_FREE, ST_BURST, ST_LOCKED} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] burst_load;
    logic       grant_q, grant_d;
    logic       master_q, mastlock_q;
    logic       req0, req1, owner_lock, lock_hold, contested;
    logic       arb_point, winner;

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic       rr_q, rr_d;
`endif

    always_comb begin
        case (hburst)
            3'b010, 3'b011: burst_load = 4'd3;
            3'b100, 3'b101: burst_load = 4'd7;
            3'b110, 3'b111: burst_load = 4'd15;
            default:        burst_load = 4'd0;
        endcase
    end

    assign req0       = hbusreq0 | hlock0;
    assign req1       = hbusreq1 | hlock1;
    assign owner_lock = grant_q ? hlock1 : hlock0;
    assign lock_hold  = (state_q == ST_LOCKED) && owner_lock;
    assign contested  = req0 && req1 && !lock_hold;

    always_comb begin
        if (lock_hold) begin
            winner = grant_q;
        end else if (contested) begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
            winner = ~rr_q;
`else
            winner = 1'b1;
`endif
        end else begin
            winner = req1;
        end
    end

    // A nonzero counter means a fixed-length burst is in flight, locked or not.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        arb_point = 1'b0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
        rr_d      = rr_q;
`endif
        if (cnt_q != 4'd0) begin
            case (htrans)
                TR_SEQ: begin
                    if (cnt_q == 4'd1) arb_point = 1'b1;
                    else               cnt_d = cnt_q - 4'd1;
                end
                TR_BUSY: ;
                default: arb_point = 1'b1;
            endcase
        end else if (htrans == TR_IDLE) begin
            arb_point = 1'b1;
        end else if (htrans != TR_BUSY && burst_load == 4'd0) begin
            arb_point = 1'b1;
        end else if (htrans == TR_NONSEQ && burst_load != 4'd0) begin
            cnt_d = burst_load;
            if (state_q == ST_FREE) state_d = ST_BURST;
        end

        if (arb_point) begin
            cnt_d   = 4'd0;
            grant_d = winner;
            state_d = (winner ? hlock1 : hlock0) ? ST_LOCKED : ST_FREE;
`ifdef AHB_ARB_ROUND_ROBIN_EN
            if (contested) rr_d = winner;
`endif
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= ST_FREE;
            cnt_q      <= 4'd0;
            grant_q    <= 1'b0;
            master_q   <= 1'b0;
            mastlock_q <= 1'b0;
        end else if (hready) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            master_q   <= grant_q;
            mastlock_q <= (state_q == ST_LOCKED);
        end
    end

`ifdef AHB_ARB_ROUND_ROBIN_EN
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn)    rr_q <= 1'b0;
        else if (hready) rr_q <= rr_d;
    end
`endif

    assign hgrant0   = ~grant_q;
    assign hgrant1   = grant_q;
    assign hmaster   = master_q;
    assign hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// tb/tb_ahb_arbiter_2m.sv - Directed and random checks of ahb_arbiter_2m against a reference model
module tb_ahb_arbiter_2m;
    logic       hclk = 1'b0;
    logic       hresetn = 1'b0;
    logic       hbusreq0 = 1'b0, hbusreq1 = 1'b0, hlock0 = 1'b0, hlock1 = 1'b0;
    logic [1:0] htrans = 2'b00;
    logic [2:0] hburst = 3'b000;
    logic       hready = 1'b1;
    logic       hgrant0, hgrant1, hmaster, hmastlock;

    int tests = 0;
    int fails = 0;

    // Reference state: owner of the grant, its lock status, SEQ beats still owed.
    bit m_owner, m_locked, m_hmaster, m_mlock, m_last;
    int m_left;
    int blen [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

    ahb_arbiter_2m dut (
        .hclk(hclk), .hresetn(hresetn),
        .hbusreq0(hbusreq0), .hbusreq1(hbusreq1),
        .hlock0(hlock0), .hlock1(hlock1),
        .htrans(htrans), .hburst(hburst), .hready(hready),
        .hgrant0(hgrant0), .hgrant1(hgrant1),
        .hmaster(hmaster), .hmastlock(hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_locked = 0; m_hmaster = 0; m_mlock = 0; m_last = 0; m_left = 0;
    endtask

    task automatic model_edge();
        bit arb, r0, r1, w;
        if (!hready) return;
        m_hmaster = m_owner;
        m_mlock   = m_locked;
        arb = 0;
        if (m_left > 0) begin
            if (htrans == 2'b11) begin
                m_left = m_left - 1;
                if (m_left == 0) arb = 1;
            end else if (htrans != 2'b01) begin
                arb = 1;
                m_left = 0;
            end
        end else if (htrans == 2'b00) begin
            arb = 1;
        end else if (htrans != 2'b01 && blen[hburst] == 1) begin
            arb = 1;
        end else if (htrans == 2'b10) begin
            m_left = blen[hburst] - 1;
        end
        if (arb) begin
            r0 = hbusreq0 | hlock0;
            r1 = hbusreq1 | hlock1;
            if (m_locked && (m_owner ? hlock1 : hlock0)) begin
                w = m_owner;
            end else if (r0 && r1) begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
                w = ~m_last;
                m_last = w;
`else
                w = 1;
`endif
            end else begin
                w = r1;
            end
            m_owner  = w;
            m_locked = w ? hlock1 : hlock0;
        end
    endtask

    task automatic step(input bit r0, input bit r1, input bit l0, input bit l1,
                        input logic [1:0] tr, input logic [2:0] bu, input bit rdy);
        hbusreq0 = r0; hbusreq1 = r1; hlock0 = l0; hlock1 = l1;
        htrans = tr; hburst = bu; hready = rdy;
        @(posedge hclk);
        model_edge();
        #1;
        check("hgrant0", hgrant0, ~m_owner);
        check("hgrant1", hgrant1, m_owner);
        check("onehot", hgrant0 ^ hgrant1, 1'b1);
        check("hmaster", hmaster, m_hmaster);
        check("hmastlock", hmastlock, m_mlock);
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        hbusreq0 = 0; hbusreq1 = 0; hlock0 = 0; hlock1 = 0;
        htrans = 2'b00; hburst = 3'b000; hready = 1'b1;
        #1;
        check("rst_hgrant0", hgrant0, 1'b1);
        check("rst_hgrant1", hgrant1, 1'b0);
        check("rst_hmaster", hmaster, 1'b0);
        check("rst_hmastlock", hmastlock, 1'b0);
        @(posedge hclk);
        @(posedge hclk);
        #2;
        hresetn = 1'b1;
        model_reset();
    endtask

    initial begin
        bit r0, r1, l0, l1, rdy;
        logic [1:0] tr;
        logic [2:0] bu;
        model_reset();
        r0 = 0; r1 = 0; l0 = 0; l1 = 0;

        // Reset, then an idle bus parks on master 0
        #3;
        do_reset();
        step(0, 0, 0, 0, 2'b00, 3'b000, 1);
        check("idle_g0", hgrant0, 1'b1);

        // INCR4 by master 0: hand over only after the third SEQ is accepted
        step(1, 1, 0, 0, 2'b10, 3'b011, 1);
        check("incr4_ns_g1", hgrant1, 1'b0);
        step(1, 1, 0, 0, 2'b11, 3'b011, 1);
        check("incr4_s1_g1", hgrant1, 1'b0);
        step(1, 1, 0, 0, 2'b11, 3'b011, 1);
        check("incr4_s2_g1", hgrant1, 1'b0);
        step(1, 1, 0, 0, 2'b11, 3'b011, 1);
        check("incr4_s3_g1", hgrant1, 1'b1);
        check("incr4_s3_hm", hmaster, 1'b0);
        step(0, 1, 0, 0, 2'b00, 3'b000, 1);
        check("incr4_hm1", hmaster, 1'b1);

        // INCR8 by master 0 with a 5-cycle wait state mid-burst
        step(1, 0, 0, 0, 2'b00, 3'b000, 1);
        step(1, 1, 0, 0, 2'b10, 3'b101, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 2'b11, 3'b101, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 2'($urandom_range(3)), 3'b101, 0);
            check("stall_g0", hgrant0, 1'b1);
            check("stall_hm", hmaster, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 2'b11, 3'b101, 1);
            check("incr8_end_g1", hgrant1, i == 3);
        end

        // Locked INCR16 + SINGLE by master 1 while master 0 keeps requesting
        do_reset();
        step(1, 0, 0, 1, 2'b00, 3'b000, 1);
        check("lock_g1", hgrant1, 1'b1);
        step(1, 0, 0, 1, 2'b10, 3'b111, 1);
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 0, 1, 2'b11, 3'b111, 1);
            check("lock_beat_g1", hgrant1, 1'b1);
            check("lock_beat_ml", hmastlock, 1'b1);
        end
        step(1, 0, 0, 1, 2'b10, 3'b000, 1);
        check("lock_single_g1", hgrant1, 1'b1);
        step(1, 0, 0, 0, 2'b01, 3'b000, 1);
        check("unlock_busy_g1", hgrant1, 1'b1);
        step(1, 0, 0, 0, 2'b00, 3'b000, 1);
        check("unlock_g0", hgrant0, 1'b1);

        // Continuous contention with SINGLE transfers
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 0, 2'b10, 3'b000, 1);
`ifdef AHB_ARB_ROUND_ROBIN_EN
            check("contend_g1", hgrant1, (i % 2) == 0);
`else
            check("contend_g1", hgrant1, 1'b1);
`endif
        end

        // Reset at beat 4 of a master 1 WRAP8; the burst must not resume
        do_reset();
        step(0, 1, 0, 0, 2'b00, 3'b000, 1);
        step(0, 1, 0, 0, 2'b10, 3'b100, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 2'b11, 3'b100, 1);
        check("wrap8_hm1", hmaster, 1'b1);
        do_reset();
        step(0, 0, 0, 0, 2'b11, 3'b100, 1);
        check("post_rst_g0", hgrant0, 1'b1);
        step(0, 1, 0, 0, 2'b11, 3'b000, 1);
        check("post_rst_cnt0", hgrant1, 1'b1);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) r0 = ~r0;
            if ($urandom_range(3) == 0) r1 = ~r1;
            if ($urandom_range(15) == 0) l0 = ~l0;
            if ($urandom_range(15) == 0) l1 = ~l1;
            case ($urandom_range(9))
                0, 1:    tr = 2'b00;
                2:       tr = 2'b01;
                3, 4:    tr = 2'b10;
                default: tr = 2'b11;
            endcase
            bu  = 3'($urandom_range(7));
            rdy = ($urandom_range(4) != 0);
            step(r0, r1, l0, l1, tr, bu, rdy);
            if (i == 1500) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
